// File: rtl/filtro_azar_pkg.sv
// Shared constants and helpers for the filtro_azar glitch filter.
// FILTRO_AZAR_SAT(w) gives the all-ones saturation value of a w-bit counter.
`ifndef FILTRO_AZAR_SAT
`define FILTRO_AZAR_SAT(w) {(w){1'b1}}
`endif

package filtro_azar_pkg;

  localparam int DEF_STABLE      = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filtro_canal.sv
// One filter channel: synchroniser, stability counter, filtered q, edge pulses.
// o_glitch is combinational; the top level registers the OR over channels.
module filtro_canal
  import filtro_azar_pkg::*;
#(
  parameter int   STABLE      = DEF_STABLE,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INIT        = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch
);

  localparam int CW = clog2_min1(STABLE);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_diff;
  logic                   w_take;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_s != r_q);
  assign w_take = i_tick && w_diff && (r_cnt == LAST);
  // A run of disagreement that ends before qualifying is a rejected glitch.
  assign o_glitch = i_tick && !w_diff && (r_cnt != '0);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= {SYNC_STAGES{INIT}};
      r_cnt  <= '0;
      r_q    <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_rise <= w_take && w_s;
      r_fall <= w_take && !w_s;
      if (i_tick) begin
        if (!w_diff || w_take) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_take) begin
          r_q <= w_s;
        end
      end
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/filtro_azar.sv
// WIDTH-channel hazard filter: per-channel qualification plus shared glitch pulse.
// Define GLITCH_CNT_EN to build the saturating glitch counter; otherwise o_glitch_cnt is 0.
module filtro_azar
  import filtro_azar_pkg::*;
#(
  parameter int   WIDTH       = 4,
  parameter int   STABLE      = DEF_STABLE,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INIT        = 1'b0,
  parameter int   CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_glitch,
  output logic [CNT_W-1:0] o_glitch_cnt
);

  logic [WIDTH-1:0] w_glitch_ch;
  logic             r_glitch;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    filtro_canal #(
      .STABLE      (STABLE),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (INIT)
    ) u_canal (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_tick    (i_tick),
      .i_d       (i_d[g]),
      .o_q       (o_q[g]),
      .o_rise    (o_rise[g]),
      .o_fall    (o_fall[g]),
      .o_glitch  (w_glitch_ch[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= |w_glitch_ch;
    end
  end

  assign o_glitch = r_glitch;

`ifdef GLITCH_CNT_EN
  logic [CNT_W-1:0] r_glitch_cnt;

  // Counts events, not channels: several channels on one edge add one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_glitch_cnt <= '0;
    end else if ((|w_glitch_ch) && (r_glitch_cnt != `FILTRO_AZAR_SAT(CNT_W))) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign o_glitch_cnt = r_glitch_cnt;
`else
  assign o_glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_filtro_azar.sv
// Self-checking bench for filtro_azar against a run-length reference model.
// A second instance with CNT_W=2 shares the stimulus to observe counter saturation.
module tb_filtro_azar;

  localparam int W  = 4;
  localparam int ST = 4;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tick;
  logic [W-1:0] d;
  logic [W-1:0] q, rise, fall, q2, rise2, fall2;
  logic         glitch, glitch2;
  logic [7:0]   gcnt;
  logic [1:0]   gcnt2;

  always #5 clk = ~clk;

  filtro_azar #(.WIDTH(W), .STABLE(ST), .SYNC_STAGES(SS), .INIT(1'b0), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick(tick), .i_d(d),
    .o_q(q), .o_rise(rise), .o_fall(fall), .o_glitch(glitch), .o_glitch_cnt(gcnt)
  );

  filtro_azar #(.WIDTH(W), .STABLE(ST), .SYNC_STAGES(SS), .INIT(1'b0), .CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick(tick), .i_d(d),
    .o_q(q2), .o_rise(rise2), .o_fall(fall2), .o_glitch(glitch2), .o_glitch_cnt(gcnt2)
  );

  // Reference model: delay line for the synchroniser, run length of disagreement per channel.
  logic [W-1:0] m_pipe [SS];
  logic [W-1:0] m_q, m_rise, m_fall;
  logic         m_glitch;
  int           m_run [W];
  int           m_gcnt, m_gcnt2;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int exp_cnt(input int v);
`ifdef GLITCH_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_q = '0; m_rise = '0; m_fall = '0; m_glitch = 1'b0;
    m_gcnt = 0; m_gcnt2 = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic         g;
    s = m_pipe[SS-1];
    for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = d;
    m_rise = '0; m_fall = '0; g = 1'b0;
    if (tick) begin
      for (int i = 0; i < W; i++) begin
        if (s[i] !== m_q[i]) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            m_q[i] = s[i];
            m_run[i] = 0;
            if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
          end
        end else begin
          if (m_run[i] > 0) g = 1'b1;
          m_run[i] = 0;
        end
      end
    end
    m_glitch = g;
    if (g) begin
      if (m_gcnt < 255) m_gcnt++;
      if (m_gcnt2 < 3) m_gcnt2++;
    end
  endtask

  task automatic cycle(input logic t, input logic [W-1:0] dv);
    tick = t;
    d    = dv;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] dv);
    d = dv;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick = 1'b1; d = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (q !== 4'h0) $display("FAIL reset_q got %h want 0", q); else n_pass++;
    n_checks++; if (rise !== 4'h0) $display("FAIL reset_rise got %h want 0", rise); else n_pass++;
    n_checks++; if (fall !== 4'h0) $display("FAIL reset_fall got %h want 0", fall); else n_pass++;
    n_checks++; if (glitch !== 1'b0) $display("FAIL reset_glitch got %b want 0", glitch); else n_pass++;
    n_checks++; if (gcnt !== 8'd0) $display("FAIL reset_gcnt got %0d want 0", gcnt); else n_pass++;
    n_checks++; if (gcnt2 !== 2'd0) $display("FAIL reset_gcnt2 got %0d want 0", gcnt2); else n_pass++;
    d = 4'h0;
    reset_n = 1'b1;
    cycle(1'b1, 4'h0);
    n_checks++; if (rise !== 4'h0) $display("FAIL release_rise got %h want 0", rise); else n_pass++;
    n_checks++; if (q !== 4'h0) $display("FAIL release_q got %h want 0", q); else n_pass++;
  endtask

  task automatic test_rise();
    do_reset(4'h0);
    for (int e = 1; e <= 8; e++) begin
      cycle(1'b1, 4'h1);
      n_checks++;
      if (q[0] !== (e >= 6)) $display("FAIL rise_q0 edge=%0d got %b want %b", e, q[0], (e >= 6));
      else n_pass++;
      n_checks++;
      if (rise !== ((e == 6) ? 4'h1 : 4'h0)) $display("FAIL rise_pulse edge=%0d got %h want %h", e, rise, ((e == 6) ? 4'h1 : 4'h0));
      else n_pass++;
      n_checks++;
      if (q[3:1] !== 3'b000) $display("FAIL rise_others edge=%0d got %b want 000", e, q[3:1]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    do_reset(4'h0);
    for (int e = 1; e <= 12; e++) begin
      cycle(1'b1, (e <= 2) ? 4'h2 : 4'h0);
      if (glitch === 1'b1) pulses++;
      n_checks++;
      if (glitch !== m_glitch) $display("FAIL glitch_pulse edge=%0d got %b want %b", e, glitch, m_glitch);
      else n_pass++;
    end
    n_checks++; if (pulses !== 1) $display("FAIL glitch_count_pulses got %0d want 1", pulses); else n_pass++;
    n_checks++; if (q !== 4'h0) $display("FAIL glitch_q got %h want 0", q); else n_pass++;
    n_checks++;
    if (gcnt !== 8'(exp_cnt(1))) $display("FAIL glitch_cnt got %0d want %0d", gcnt, exp_cnt(1));
    else n_pass++;
  endtask

  task automatic test_tick();
    logic [W-1:0] dv;
    do_reset(4'h0);
    for (int c = 0; c < 40; c++) begin
      dv = 4'h4;
      if (c >= 9 && c <= 11) dv[3] = 1'b1;
      cycle((c % 4) == 0, dv);
      n_checks++;
      if (q[2] !== (c >= 16)) $display("FAIL tick_q2 c=%0d got %b want %b", c, q[2], (c >= 16));
      else n_pass++;
      n_checks++;
      if (q !== m_q) $display("FAIL tick_model_q c=%0d got %h want %h", c, q, m_q);
      else n_pass++;
    end
    n_checks++; if (q[3] !== 1'b0) $display("FAIL tick_filtered got %b want 0", q[3]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nrise [W];
    for (int i = 0; i < W; i++) nrise[i] = 0;
    do_reset(4'h0);
    for (int e = 0; e < 8; e++) cycle(1'b1, 4'hF);
    n_checks++; if (q !== 4'hF) $display("FAIL mid_qualify got %h want F", q); else n_pass++;
    for (int e = 0; e < 3; e++) cycle(1'b1, 4'h0);
    d = 4'hF;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (q !== 4'h0) $display("FAIL mid_async_q got %h want 0", q); else n_pass++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycle(1'b1, 4'hF);
      for (int i = 0; i < W; i++) if (rise[i] === 1'b1) nrise[i]++;
      n_checks++;
      if (q !== ((e >= 6) ? 4'hF : 4'h0)) $display("FAIL mid_requal edge=%0d got %h want %h", e, q, ((e >= 6) ? 4'hF : 4'h0));
      else n_pass++;
    end
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if (nrise[i] !== 1) $display("FAIL mid_rise_count bit=%0d got %0d want 1", i, nrise[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int expv [5];
    expv = '{1, 2, 3, 3, 3};
    do_reset(4'h0);
    for (int g = 0; g < 5; g++) begin
      cycle(1'b1, 4'h1);
      cycle(1'b1, 4'h1);
      for (int e = 0; e < 6; e++) cycle(1'b1, 4'h0);
      n_checks++;
      if (gcnt2 !== 2'(exp_cnt(expv[g]))) $display("FAIL sat_cnt2 n=%0d got %0d want %0d", g + 1, gcnt2, exp_cnt(expv[g]));
      else n_pass++;
      n_checks++;
      if (gcnt !== 8'(exp_cnt(g + 1))) $display("FAIL sat_cnt8 n=%0d got %0d want %0d", g + 1, gcnt, exp_cnt(g + 1));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] dv;
    logic [W-1:0] mask;
    dv = 4'h0;
    do_reset(4'h0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++) mask[i] = ($urandom_range(0, 5) == 0);
      dv = dv ^ mask;
      cycle($urandom_range(0, 3) != 0, dv);
      n_checks++; if (q !== m_q) $display("FAIL rnd_q c=%0d got %h want %h", c, q, m_q); else n_pass++;
      n_checks++; if (rise !== m_rise) $display("FAIL rnd_rise c=%0d got %h want %h", c, rise, m_rise); else n_pass++;
      n_checks++; if (fall !== m_fall) $display("FAIL rnd_fall c=%0d got %h want %h", c, fall, m_fall); else n_pass++;
      n_checks++; if (glitch !== m_glitch) $display("FAIL rnd_glitch c=%0d got %b want %b", c, glitch, m_glitch); else n_pass++;
      n_checks++;
      if (gcnt !== 8'(exp_cnt(m_gcnt))) $display("FAIL rnd_gcnt c=%0d got %0d want %0d", c, gcnt, exp_cnt(m_gcnt));
      else n_pass++;
      n_checks++;
      if (gcnt2 !== 2'(exp_cnt(m_gcnt2))) $display("FAIL rnd_gcnt2 c=%0d got %0d want %0d", c, gcnt2, exp_cnt(m_gcnt2));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_tick();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
